// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Data-memory responder for the core load/store port. Accepts one
//             request at a time over a valid/ready handshake, waits LATENCY
//             cycles, then presents a held response. Word-organised RAM with
//             byte-lane writes; flags misaligned, out-of-range and empty-store
//             accesses.
//  Options  : define DMEM_STATS_EN to add load/store/error counters.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [15:0] stat_errs
`endif
);

    localparam int unsigned c_idx_w = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_span  = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  c_lat   = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [3:0]           be_q, be_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [c_idx_w-1:0]   idx_q, idx_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [31:0]          mem [DEPTH_WORDS];

    logic [31:0]          w_offset;
    logic                 w_req_err;
    logic                 w_accept;
    logic                 w_rsp_hs;
    logic                 w_enter_resp;
    logic                 w_commit;

    // Ready only in IDLE and forced low while reset is held
    assign req_ready = (state_q == S_IDLE) & ~rst;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Request decode, next-state and response data computation
    always_comb begin
        w_offset     = req_addr - BASE_ADDR;
        w_req_err    = (req_addr[1:0] != 2'b00) | (w_offset >= c_span)
                     | (req_we & (req_be == 4'b0000));
        w_accept     = req_valid & req_ready;
        w_rsp_hs     = (state_q == S_RESP) & rsp_ready;

        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        err_d        = err_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        idx_d        = idx_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        w_enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    we_d    = req_we;
                    err_d   = w_req_err;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    idx_d   = w_offset[c_idx_w+1:2];
                    cnt_d   = c_lat;
                    if (c_lat == 4'd0) begin
                        state_d      = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    state_d     = S_IDLE;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The RAM is sampled on the same edge that enters RESP
        if (w_enter_resp) begin
            rsp_err_d   = err_d;
            rsp_rdata_d = (we_d | err_d) ? 32'h0 : mem[idx_d];
        end

        w_commit = w_enter_resp & we_d & ~err_d;
    end

    // Control FSM, latched request and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            be_q        <= 4'd0;
            wdata_q     <= 32'h0;
            idx_q       <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            err_q       <= err_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-lane store commit; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) begin
                    mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] stat_loads_q, stat_loads_d;
    logic [31:0] stat_stores_q, stat_stores_d;
    logic [15:0] stat_errs_q, stat_errs_d;

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;

    // Count completed responses by kind on the response handshake
    always_comb begin
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_errs_d   = stat_errs_q;
        if (w_rsp_hs) begin
            if (err_q)     stat_errs_d   = stat_errs_q + 16'd1;
            else if (we_q) stat_stores_d = stat_stores_q + 32'd1;
            else           stat_loads_d  = stat_loads_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_loads_q  <= 32'd0;
            stat_stores_q <= 32'd0;
            stat_errs_q   <= 16'd0;
        end else begin
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_errs_q   <= stat_errs_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Self-checking bench for dmem_responder. One instance with the
//             default LATENCY=2 and one with LATENCY=0 and a non-zero base.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int unsigned LAT_A  = 2;
    localparam logic [31:0] BASE_Z = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    logic        req_valid_z, req_ready_z, req_we_z, rsp_valid_z, rsp_ready_z, rsp_err_z;
    logic [31:0] req_addr_z, req_wdata_z, rsp_rdata_z;
    logic [3:0]  req_be_z;

`ifdef DMEM_STATS_EN
    logic [31:0] stat_loads, stat_stores, stat_loads_z, stat_stores_z;
    logic [15:0] stat_errs, stat_errs_z;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl  [22];
    vec_t tbl0 [6];

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(LAT_A)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE_Z), .LATENCY(0)) u_dut_z (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
        .req_addr(req_addr_z), .req_be(req_be_z), .req_wdata(req_wdata_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
        .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
`ifdef DMEM_STATS_EN
        , .stat_loads(stat_loads_z), .stat_stores(stat_stores_z), .stat_errs(stat_errs_z)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance with rsp_ready high.
    // Junk is driven on req_* during the wait to show it is ignored.
    task automatic txn(input string nm, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        int cyc;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
        rsp_ready = 1'b1;
        chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_we = ~we; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'h0;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 1'b0;
        chk({nm, " latency"}, 32'(cyc), 32'(LAT_A + 1));
        chk({nm, " rdata"}, rsp_rdata, exp_rd);
        chk({nm, " err"}, 32'(rsp_err), 32'(exp_err));
        chk({nm, " ready_in_resp"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk({nm, " valid_after_hs"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int cyc;

        //            we    addr            be     wdata          exp_rdata      err
        tbl[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0010, 4'h1, 32'h000000AA, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEAA, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0010, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[5]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEAA, 1'b0};
        tbl[6]  = '{1'b0, 32'h0000_0012, 4'h0, 32'h0,        32'h0,        1'b1};
        tbl[7]  = '{1'b0, 32'h0000_1000, 4'h0, 32'h0,        32'h0,        1'b1};
        tbl[8]  = '{1'b1, 32'h0000_0012, 4'hF, 32'h11111111, 32'h0,        1'b1};
        tbl[9]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h01020304, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 32'h0000_1000, 4'hF, 32'h55555555, 32'h0,        1'b1};
        tbl[11] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,        32'h01020304, 1'b0};
        tbl[12] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEAA, 1'b0};
        tbl[13] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[14] = '{1'b0, 32'h0000_0FFC, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[15] = '{1'b1, 32'h0000_0014, 4'hF, 32'h00000000, 32'h0,        1'b0};
        tbl[16] = '{1'b1, 32'h0000_0014, 4'hA, 32'hAABBCCDD, 32'h0,        1'b0};
        tbl[17] = '{1'b0, 32'h0000_0014, 4'h0, 32'h0,        32'hAA00CC00, 1'b0};
        tbl[18] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,        32'h0,        1'b1};
        tbl[19] = '{1'b1, 32'h0000_0020, 4'hF, 32'h0BADF00D, 32'h0,        1'b0};
        tbl[20] = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,        32'h0BADF00D, 1'b0};
        tbl[21] = '{1'b0, 32'h0000_0014, 4'h0, 32'h0,        32'hAA00CC00, 1'b0};

        // LATENCY=0 instance, base 0x1000: 3 good loads, 2 good stores, 1 error
        tbl0[0] = '{1'b1, 32'h0000_1040, 4'hF, 32'hA5A5A5A5, 32'h0,        1'b0};
        tbl0[1] = '{1'b1, 32'h0000_1044, 4'hF, 32'h3C3C3C3C, 32'h0,        1'b0};
        tbl0[2] = '{1'b0, 32'h0000_1040, 4'h0, 32'h0,        32'hA5A5A5A5, 1'b0};
        tbl0[3] = '{1'b0, 32'h0000_1044, 4'h0, 32'h0,        32'h3C3C3C3C, 1'b0};
        tbl0[4] = '{1'b0, 32'h0000_0FFC, 4'h0, 32'h0,        32'h0,        1'b1};
        tbl0[5] = '{1'b0, 32'h0000_1040, 4'h0, 32'h0,        32'hA5A5A5A5, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_be = 4'h0; req_wdata = 32'h0;
        rsp_ready = 1'b0;
        req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = 32'h0; req_be_z = 4'h0;
        req_wdata_z = 32'h0; rsp_ready_z = 1'b0;

        // Reset state
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst req_ready_z", 32'(req_ready_z), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst req_ready", 32'(req_ready), 32'd1);
        chk("post_rst req_ready_z", 32'(req_ready_z), 32'd1);
`ifdef DMEM_STATS_EN
        chk("rst stat_loads", stat_loads, 32'd0);
        chk("rst stat_errs", 32'(stat_errs), 32'd0);
`endif

        // Table-driven transactions
        for (int i = 0; i < 22; i++) begin
            txn($sformatf("v%0d", i), tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata,
                tbl[i].exp_rdata, tbl[i].exp_err);
        end

        // Response back-pressure: outputs held, new request (a store of 0) ignored
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_we = 1'b1; req_be = 4'hF; req_wdata = 32'h0;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall latency", 32'(cyc), 32'(LAT_A + 1));
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d rdata", k), rsp_rdata, 32'hDEADBEAA);
            chk($sformatf("stall%0d req_ready", k), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall hs valid", 32'(rsp_valid), 32'd0);
        chk("stall hs req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        txn("stall recheck", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0);

        // Reset while a response is held
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rstresp pre rdata", rsp_rdata, 32'hDEADBEAA);
        rst = 1'b1;
        #1;
        chk("rstresp valid", 32'(rsp_valid), 32'd0);
        chk("rstresp rdata", rsp_rdata, 32'd0);
        chk("rstresp req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstresp release ready", 32'(req_ready), 32'd1);

        // Reset during the wait of a store: the store must never commit
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF;
        req_wdata = 32'h12345678; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstwait valid", 32'(rsp_valid), 32'd0);
        chk("rstwait err", 32'(rsp_err), 32'd0);
        chk("rstwait req_ready", 32'(req_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstwait held valid", 32'(rsp_valid), 32'd0);
        chk("rstwait held rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("rstwait release ready", 32'(req_ready), 32'd1);
        txn("rstwait old value", 1'b0, 32'h20, 4'h0, 32'h0, 32'h0BADF00D, 1'b0);

        // LATENCY=0, back-to-back with rsp_ready held high
        rsp_ready_z = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid_z = 1'b1; req_we_z = tbl0[i].we; req_addr_z = tbl0[i].addr;
            req_be_z = tbl0[i].be; req_wdata_z = tbl0[i].wdata;
            chk($sformatf("z%0d req_ready", i), 32'(req_ready_z), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("z%0d rsp_valid", i), 32'(rsp_valid_z), 32'd1);
            chk($sformatf("z%0d rdata", i), rsp_rdata_z, tbl0[i].exp_rdata);
            chk($sformatf("z%0d err", i), 32'(rsp_err_z), 32'(tbl0[i].exp_err));
            chk($sformatf("z%0d ready_in_resp", i), 32'(req_ready_z), 32'd0);
            req_valid_z = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("z%0d idle", i), 32'(rsp_valid_z), 32'd0);
        end
`ifdef DMEM_STATS_EN
        chk("stat_loads_z", stat_loads_z, 32'd3);
        chk("stat_stores_z", stat_stores_z, 32'd2);
        chk("stat_errs_z", 32'(stat_errs_z), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
